// File: rtl/csr_trap_unit.sv
// ============================================================================
// Module   : csr_trap_unit
// Purpose  : Machine-mode CSR file with ecall/mret/external-interrupt trap logic
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_trap_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter int              ECALL_CAUSE = 11,
  parameter int              IRQ_CAUSE   = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            ecall,
  input  logic            mret,
  input  logic            instr_retire,
  input  logic            ext_irq,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_target,
  output logic            irq_taken
);

  localparam logic [11:0] c_ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] c_ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] c_ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] c_ADDR_MEPC      = 12'h341;
  localparam logic [11:0] c_ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] c_ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] c_ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] c_ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] c_ADDR_MINSTRETH = 12'hB82;

  localparam bit              c_HAS_HI       = (XLEN == 32);
  localparam logic [XLEN-1:0] c_ECALL_MCAUSE = XLEN'(ECALL_CAUSE);
  localparam logic [XLEN-1:0] c_IRQ_MCAUSE   = {1'b1, (XLEN-1)'(IRQ_CAUSE)};
  localparam logic [XLEN-1:0] c_ALIGN_MASK   = ~XLEN'(3);

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] csr_new;
  logic            csr_hit;
  logic            csr_we;
  logic            irq_take;

  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mpie_q;
    mstatus_val[3]     = mie_q;
  end

  // The high-half counter aliases only exist on 32-bit builds.
  always_comb begin
    csr_hit   = 1'b1;
    csr_rdata = '0;
    case (csr_addr)
      c_ADDR_MSTATUS:   csr_rdata = mstatus_val;
      c_ADDR_MTVEC:     csr_rdata = mtvec_q;
      c_ADDR_MSCRATCH:  csr_rdata = mscratch_q;
      c_ADDR_MEPC:      csr_rdata = mepc_q;
      c_ADDR_MCAUSE:    csr_rdata = mcause_q;
      c_ADDR_MCYCLE:    csr_rdata = mcycle_q[XLEN-1:0];
      c_ADDR_MINSTRET:  csr_rdata = minstret_q[XLEN-1:0];
      c_ADDR_MCYCLEH: begin
        if (c_HAS_HI) csr_rdata = XLEN'(mcycle_q[63:32]);
        else          csr_hit   = 1'b0;
      end
      c_ADDR_MINSTRETH: begin
        if (c_HAS_HI) csr_rdata = XLEN'(minstret_q[63:32]);
        else          csr_hit   = 1'b0;
      end
      default:          csr_hit = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op)
      2'b01:   csr_new = csr_wdata;
      2'b10:   csr_new = csr_rdata | csr_wdata;
      2'b11:   csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase
  end

  assign csr_illegal = (csr_op != 2'b00) && !csr_hit;
  assign irq_take    = ext_irq & mie_q & instr_retire & ~ecall & ~mret;
  assign irq_taken   = irq_take;
  assign trap_valid  = ecall | irq_take | mret;
  assign trap_target = (mret && !ecall && !irq_take) ? mepc_q : mtvec_q;
  assign csr_we      = (csr_op != 2'b00) && csr_hit && !ecall && !irq_take && !mret;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mscratch_d = mscratch_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instr_retire};

    if (ecall) begin
      mepc_d   = pc;
      mcause_d = c_ECALL_MCAUSE;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (irq_take) begin
      mepc_d   = pc + XLEN'(4);
      mcause_d = c_IRQ_MCAUSE;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d    = mpie_q;
      mpie_d   = 1'b1;
    end else if (csr_we) begin
      // Counter writes replace one half and hold the other, dropping this cycle's increment.
      case (csr_addr)
        c_ADDR_MSTATUS: begin
          mie_d  = csr_new[3];
          mpie_d = csr_new[7];
        end
        c_ADDR_MTVEC:     mtvec_d    = csr_new & c_ALIGN_MASK;
        c_ADDR_MSCRATCH:  mscratch_d = csr_new;
        c_ADDR_MEPC:      mepc_d     = csr_new & c_ALIGN_MASK;
        c_ADDR_MCAUSE:    mcause_d   = csr_new;
        c_ADDR_MCYCLE: begin
          mcycle_d              = mcycle_q;
          mcycle_d[XLEN-1:0]    = csr_new;
        end
        c_ADDR_MINSTRET: begin
          minstret_d            = minstret_q;
          minstret_d[XLEN-1:0]  = csr_new;
        end
        c_ADDR_MCYCLEH:   mcycle_d   = {csr_new[31:0], mcycle_q[31:0]};
        c_ADDR_MINSTRETH: minstret_d = {csr_new[31:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mscratch_q <= mscratch_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
// ============================================================================
// Module   : tb_csr_trap_unit
// Purpose  : Directed bench for csr_trap_unit with a per-cycle reference model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        ecall, mret, instr_retire, ext_irq;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        irq_taken;

  int vectors     = 0;
  int miscompares = 0;

  csr_trap_unit #(
    .XLEN(32), .MTVEC_RST(32'h0), .ECALL_CAUSE(11), .IRQ_CAUSE(11)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .ecall(ecall), .mret(mret), .instr_retire(instr_retire), .ext_irq(ext_irq),
    .trap_valid(trap_valid), .trap_target(trap_target), .irq_taken(irq_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural state as plain variables
  bit          m_valid = 1'b0;
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch;
  logic [63:0] m_cyc, m_ret;

  function automatic logic [32:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3)};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'hB00: return {1'b1, m_cyc[31:0]};
      12'hB02: return {1'b1, m_ret[31:0]};
      12'hB80: return {1'b1, m_cyc[63:32]};
      12'hB82: return {1'b1, m_ret[63:32]};
      default: return 33'h0;
    endcase
  endfunction

  initial begin
    bit          irq, hit, n_mie, n_mpie;
    logic [32:0] rd;
    logic [31:0] oldv, newv, n_mtvec, n_mepc, n_mcause, n_mscr;
    logic [63:0] n_cyc, n_ret;
    forever begin
      @(negedge clk);
      rd  = m_read(csr_addr);
      hit = rd[32];
      irq = ext_irq && m_mie && instr_retire && !ecall && !mret;
      if (m_valid) begin
        chk("model.rdata",   csr_rdata, rd[31:0]);
        chk("model.illegal", 32'(csr_illegal), 32'((csr_op != 0) && !hit));
        chk("model.irq",     32'(irq_taken), 32'(irq));
        chk("model.tvalid",  32'(trap_valid), 32'(ecall || mret || irq));
        chk("model.ttarget", trap_target, (mret && !ecall && !irq) ? m_mepc : m_mtvec);
      end
      n_mie = m_mie; n_mpie = m_mpie; n_mtvec = m_mtvec; n_mepc = m_mepc;
      n_mcause = m_mcause; n_mscr = m_mscratch;
      n_cyc = m_cyc + 1;
      n_ret = m_ret + (instr_retire ? 64'd1 : 64'd0);
      if (ecall) begin
        n_mepc = pc; n_mcause = 32'd11; n_mpie = m_mie; n_mie = 1'b0;
      end else if (irq) begin
        n_mepc = pc + 4; n_mcause = 32'h8000_000B; n_mpie = m_mie; n_mie = 1'b0;
      end else if (mret) begin
        n_mie = m_mpie; n_mpie = 1'b1;
      end else if (csr_op != 0 && hit) begin
        oldv = rd[31:0];
        newv = (csr_op == 2'b01) ? csr_wdata :
               (csr_op == 2'b10) ? (oldv | csr_wdata) : (oldv & ~csr_wdata);
        case (csr_addr)
          12'h300: begin n_mie = newv[3]; n_mpie = newv[7]; end
          12'h305: n_mtvec  = {newv[31:2], 2'b00};
          12'h340: n_mscr   = newv;
          12'h341: n_mepc   = {newv[31:2], 2'b00};
          12'h342: n_mcause = newv;
          12'hB00: n_cyc    = {m_cyc[63:32], newv};
          12'hB02: n_ret    = {m_ret[63:32], newv};
          12'hB80: n_cyc    = {newv, m_cyc[31:0]};
          12'hB82: n_ret    = {newv, m_ret[31:0]};
          default: ;
        endcase
      end
      @(posedge clk);
      if (rst) begin
        m_valid = 1'b1;
        m_mie = 1'b0; m_mpie = 1'b0; m_mtvec = 32'h0; m_mepc = 32'h0;
        m_mcause = 32'h0; m_mscratch = 32'h0; m_cyc = 64'h0; m_ret = 64'h0;
      end else if (m_valid) begin
        m_mie = n_mie; m_mpie = n_mpie; m_mtvec = n_mtvec; m_mepc = n_mepc;
        m_mcause = n_mcause; m_mscratch = n_mscr; m_cyc = n_cyc; m_ret = n_ret;
      end
    end
  end

  task automatic idle();
    pc = 32'h0; csr_addr = 12'h0; csr_op = 2'b00; csr_wdata = 32'h0;
    ecall = 1'b0; mret = 1'b0; instr_retire = 1'b0; ext_irq = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic csr_acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_op = op; csr_addr = a; csr_wdata = d;
    step();
  endtask

  task automatic peek(input logic [11:0] a, input logic [31:0] exp, input string nm);
    csr_addr = a;
    @(negedge clk);
    chk(nm, csr_rdata, exp);
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) step();

    peek(12'hB00, 32'd5, "rst.mcycle");
    @(negedge clk);
    chk("rst.tvalid", 32'(trap_valid), 32'd0);
    chk("rst.ttarget", trap_target, 32'h0);
    step();
    peek(12'hB02, 32'd0, "rst.minstret");
    peek(12'h300, 32'h1800, "rst.mstatus");

    csr_acc(2'b01, 12'h305, 32'h8000_0103);
    peek(12'h305, 32'h8000_0100, "mtvec.align");
    csr_acc(2'b10, 12'h300, 32'h8);
    peek(12'h300, 32'h1808, "mstatus.set");
    csr_acc(2'b11, 12'h300, 32'h8);
    peek(12'h300, 32'h1800, "mstatus.clr");
    csr_acc(2'b10, 12'h300, 32'h8);

    pc = 32'h8000_0010; ecall = 1'b1;
    @(negedge clk);
    chk("ecall.ttarget", trap_target, 32'h8000_0100);
    step();
    peek(12'h341, 32'h8000_0010, "ecall.mepc");
    peek(12'h342, 32'd11, "ecall.mcause");
    peek(12'h300, 32'h1880, "ecall.mstatus");
    mret = 1'b1;
    @(negedge clk);
    chk("mret.ttarget", trap_target, 32'h8000_0010);
    step();
    peek(12'h300, 32'h1888, "mret.mstatus");

    ext_irq = 1'b1; instr_retire = 1'b1; pc = 32'h8000_0020;
    @(negedge clk);
    chk("irq.taken", 32'(irq_taken), 32'd1);
    step();
    peek(12'h341, 32'h8000_0024, "irq.mepc");
    peek(12'h342, 32'h8000_000B, "irq.mcause");
    ext_irq = 1'b1; instr_retire = 1'b1; pc = 32'h8000_0030;
    @(negedge clk);
    chk("irq.masked", 32'(trap_valid), 32'd0);
    step();

    csr_acc(2'b01, 12'hB00, 32'hFFFF_FFFF);
    peek(12'hB00, 32'hFFFF_FFFF, "mcycle.written");
    peek(12'hB00, 32'h0, "mcycle.wrap");
    peek(12'hB80, 32'h1, "mcycleh.carry");

    csr_acc(2'b01, 12'h340, 32'h1234_5678);
    ecall = 1'b1; mret = 1'b1; pc = 32'h8000_0040;
    csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("both.ttarget", trap_target, 32'h8000_0100);
    step();
    peek(12'h340, 32'h1234_5678, "both.mscratch");

    csr_op = 2'b01; csr_addr = 12'h7C0; csr_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("bad.illegal", 32'(csr_illegal), 32'd1);
    chk("bad.rdata", csr_rdata, 32'h0);
    step();

    csr_acc(2'b01, 12'h341, 32'h8000_0203);
    peek(12'h341, 32'h8000_0200, "mepc.align");
    csr_acc(2'b01, 12'h342, 32'hFFFF_FFFF);

    rst = 1'b1; ecall = 1'b1; pc = 32'h8000_0050;
    csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h5555_5555;
    step();
    rst = 1'b0;
    peek(12'hB00, 32'h0, "midrst.mcycle");
    peek(12'h300, 32'h1800, "midrst.mstatus");
    peek(12'h340, 32'h0, "midrst.mscratch");
    peek(12'h305, 32'h0, "midrst.mtvec");

    for (int i = 0; i < 3; i++) begin
      instr_retire = 1'b1;
      step();
    end
    peek(12'hB02, 32'd3, "minstret.count");
    instr_retire = 1'b1;
    csr_acc(2'b01, 12'hB82, 32'd5);
    peek(12'hB82, 32'd5, "minstreth.write");
    peek(12'hB02, 32'd3, "minstret.suppress");

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
